ram_port_responder: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/ram_word_array.sv | 24 ++
 rtl/ram_port_responder.sv | 134 +++++++++++++
 tb/tb_ram_port_responder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM types plus the responder FSM encoding and default RAM depth.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_DEPTH = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ramresp_t;

endpackage

// File: rtl/ram_word_array.sv
// DEPTH x 32 word storage: synchronous write, asynchronous read.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] raddr,
  output word_t            rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_port_responder.sv
// RAM-side responder with programmable access latency and word storage.
// Optional access counters (rdcnt/wrcnt) are built when RAM_STATS_EN is defined.
module ram_port_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
`ifdef RAM_STATS_EN
  ,
  output logic [31:0] rdcnt,
  output logic [31:0] wrcnt
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  // The entry cycle is itself the first BUSY cycle, so WAIT lasts LAT-1 cycles.
  localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  ramresp_t         state_reg;
  logic [3:0]       cnt_reg;
  logic             kind_wr_reg;
  logic [IDX_W-1:0] idx_reg;
  word_t            load_reg;

  logic             req, both, misaligned, out_of_range, err, valid, changed, ack_ok;
  logic [IDX_W-1:0] idx;
  word_t            rd_data;

  assign req          = ramREN | ramWEN;
  assign both         = ramREN & ramWEN;
  assign misaligned   = (ramaddr[1:0] != 2'b00);
  assign out_of_range = ({2'b00, ramaddr[31:2]} >= 32'(DEPTH));
  assign err          = both | (req & (misaligned | out_of_range));
  assign valid        = req & ~err;
  assign idx          = ramaddr[IDX_W+1:2];
  assign changed      = (ramWEN != kind_wr_reg) || (idx != idx_reg);
  assign ack_ok       = (state_reg == ACK) && !err;

  ram_word_array #(.DEPTH(DEPTH)) u_array (
    .clk  (CLK),
    .we   (ack_ok && kind_wr_reg),
    .waddr(idx_reg),
    .wdata(ramstore),
    .raddr(idx),
    .rdata(rd_data)
  );

  always_comb begin
    ramstate = FREE;
    if (!nRST) begin
      ramstate = FREE;
    end else if (err) begin
      ramstate = ERROR;
    end else begin
      case (state_reg)
        IDLE:    ramstate = valid ? BUSY : FREE;
        WAIT:    ramstate = req ? BUSY : FREE;
        ACK:     ramstate = ACCESS;
        default: ramstate = FREE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      kind_wr_reg <= 1'b0;
      idx_reg     <= '0;
      load_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid) begin
            kind_wr_reg <= ramWEN;
            idx_reg     <= idx;
            cnt_reg     <= CNT_INIT;
            if (LAT <= 1) begin
              state_reg <= ACK;
              if (!ramWEN) load_reg <= rd_data;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!valid) begin
            state_reg <= IDLE;
          end else if (changed) begin
            kind_wr_reg <= ramWEN;
            idx_reg     <= idx;
            cnt_reg     <= CNT_INIT;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ACK;
            if (!kind_wr_reg) load_reg <= rd_data;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        // A held request after ACK re-enters through IDLE, giving a fresh BUSY phase.
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ramload = load_reg;

`ifdef RAM_STATS_EN
  logic [31:0] rdcnt_reg, wrcnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdcnt_reg <= '0;
      wrcnt_reg <= '0;
    end else begin
      if (ack_ok && !kind_wr_reg && (rdcnt_reg != 32'hFFFF_FFFF)) rdcnt_reg <= rdcnt_reg + 32'd1;
      if (ack_ok && kind_wr_reg && (wrcnt_reg != 32'hFFFF_FFFF)) wrcnt_reg <= wrcnt_reg + 32'd1;
    end
  end

  assign rdcnt = rdcnt_reg;
  assign wrcnt = wrcnt_reg;
`endif

endmodule

// File: tb/tb_ram_port_responder.sv
// Bench for ram_port_responder: three instances at LAT=2,1,3 with a read-data scoreboard.
module tb_ram_port_responder;
  import cpu_types_pkg::*;

  localparam int DEPTH = 1024;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      ren [3];
  logic      wen [3];
  word_t     addr [3];
  word_t     store [3];
  word_t     load [3];
  ramstate_t st [3];
`ifdef RAM_STATS_EN
  logic [31:0] rdc [3];
  logic [31:0] wrc [3];
`endif

  int    passed = 0;
  int    total  = 0;
  word_t exp_q[$];
  word_t model [3][DEPTH];

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    localparam int L = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);
    ram_port_responder #(.LAT(L), .DEPTH(DEPTH)) u_dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .ramREN  (ren[gi]),
      .ramWEN  (wen[gi]),
      .ramaddr (addr[gi]),
      .ramstore(store[gi]),
      .ramload (load[gi]),
      .ramstate(st[gi])
`ifdef RAM_STATS_EN
      ,
      .rdcnt   (rdc[gi]),
      .wrcnt   (wrc[gi])
`endif
    );
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // One full request: hold until ACCESS, check latency and read data, then release.
  task automatic txn(input int k, input logic wr, input word_t a, input word_t d, input int lat);
    int    busy;
    bit    done, bad;
    word_t exp;
    busy = 0; done = 0; bad = 0;
    if (!wr) exp_q.push_back(model[k][a[11:2]]);
    for (int c = 0; c < 40 && !done; c++) begin
      next_cycle();
      ren[k] = ~wr; wen[k] = wr; addr[k] = a; store[k] = d;
      #4;
      if (st[k] == ACCESS) done = 1;
      else if (st[k] == BUSY) busy++;
      else bad = 1;
    end
    total++;
    if (done && !bad && busy == lat) passed++;
    else $display("FAIL txn_latency dut%0d addr %h: busy=%0d done=%0d bad=%0d want busy=%0d", k, a, busy, done, bad, lat);
    if (!wr) begin
      exp = exp_q.pop_front();
      total++;
      if (load[k] === exp) passed++;
      else $display("FAIL txn_rdata dut%0d addr %h: got %h want %h", k, a, load[k], exp);
    end else if (done) begin
      model[k][a[11:2]] = d;
    end
    next_cycle();
    ren[k] = 1'b0; wen[k] = 1'b0;
    #4;
    total++;
    if (st[k] === FREE) passed++;
    else $display("FAIL txn_release dut%0d: state %0d want %0d", k, st[k], FREE);
    $display("txn dut%0d %s addr=%h data=%h busy=%0d load=%h", k, wr ? "WR" : "RD", a, d, busy, load[k]);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ren[k] = 1'b0; wen[k] = 1'b0; addr[k] = '0; store[k] = '0;
    end
    repeat (2) next_cycle();
    #4;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (st[k] === FREE) passed++;
      else $display("FAIL reset_state dut%0d: got %0d want %0d", k, st[k], FREE);
      total++;
      if (load[k] === 32'h0) passed++;
      else $display("FAIL reset_load dut%0d: got %h want 0", k, load[k]);
    end
    nRST = 1'b1;
    $display("reset released");
  endtask

  task automatic test_lat2_write_read();
    txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2);
    txn(0, 1'b0, 32'h40, 32'h0, 2);
  endtask

  task automatic test_lat1_back_to_back();
    ramstate_t want;
    txn(1, 1'b1, 32'h0, 32'h0000_1234, 1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      ren[1] = 1'b1; addr[1] = 32'h0;
      #4;
      want = (c % 2 == 0) ? BUSY : ACCESS;
      total++;
      if (st[1] === want) passed++;
      else $display("FAIL b2b_state cycle %0d: got %0d want %0d", c, st[1], want);
      if (c >= 1) begin
        total++;
        if (load[1] === 32'h0000_1234) passed++;
        else $display("FAIL b2b_load cycle %0d: got %h want 00001234", c, load[1]);
      end
    end
    next_cycle();
    ren[1] = 1'b0;
    #4;
    $display("txn dut1 RD held 4 cycles load=%h", load[1]);
  endtask

  task automatic test_addr_change();
    ramstate_t want;
    word_t     exp;
    txn(2, 1'b1, 32'h8, 32'hAAAA_0002, 3);
    txn(2, 1'b1, 32'hC, 32'h3333_0003, 3);
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      ren[2] = 1'b1;
      addr[2] = (c == 0) ? 32'h8 : 32'hC;
      if (c == 1) exp_q.push_back(model[2][3]);
      #4;
      want = (c == 4) ? ACCESS : BUSY;
      total++;
      if (st[2] === want) passed++;
      else $display("FAIL addr_change_state cycle %0d: got %0d want %0d", c, st[2], want);
    end
    exp = exp_q.pop_front();
    total++;
    if (load[2] === exp) passed++;
    else $display("FAIL addr_change_rdata: got %h want %h", load[2], exp);
    next_cycle();
    ren[2] = 1'b0;
    #4;
    $display("txn dut2 RD 0x8->0xC restart load=%h", load[2]);
  endtask

  task automatic test_errors();
    logic  er [4];
    logic  ew [4];
    word_t ea [4];
    er[0] = 1; ew[0] = 1; ea[0] = 32'h40;
    er[1] = 1; ew[1] = 0; ea[1] = 32'h2;
    er[2] = 0; ew[2] = 1; ea[2] = 32'(DEPTH * 4);
    er[3] = 0; ew[3] = 1; ea[3] = 32'h42;
    txn(0, 1'b1, 32'h0, 32'h0000_5A5A, 2);
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) begin
        next_cycle();
        ren[0] = er[p]; wen[0] = ew[p]; addr[0] = ea[p]; store[0] = 32'h0BAD_F00D;
        #4;
        total++;
        if (st[0] === ERROR) passed++;
        else $display("FAIL error_state pat %0d cycle %0d: got %0d want %0d", p, c, st[0], ERROR);
      end
      total++;
      if (load[0] === 32'hDEAD_BEEF) passed++;
      else $display("FAIL error_load pat %0d: got %h want deadbeef", p, load[0]);
      next_cycle();
      ren[0] = 1'b0; wen[0] = 1'b0;
      #4;
      total++;
      if (st[0] === FREE) passed++;
      else $display("FAIL error_release pat %0d: got %0d want %0d", p, st[0], FREE);
      $display("err dut0 pattern %0d addr=%h ren=%0d wen=%0d", p, ea[p], er[p], ew[p]);
    end
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    txn(0, 1'b0, 32'h0, 32'h0, 2);
  endtask

  task automatic test_reset_mid_write();
    txn(0, 1'b1, 32'h10, 32'h1010_1010, 2);
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    next_cycle();
    wen[0] = 1'b1; addr[0] = 32'h10; store[0] = 32'hBAD0_0000;
    #4;
    total++;
    if (st[0] === BUSY) passed++;
    else $display("FAIL rst_mid_busy: got %0d want %0d", st[0], BUSY);
    next_cycle();
    nRST = 1'b0;
    #1;
    total++;
    if (st[0] === FREE) passed++;
    else $display("FAIL rst_mid_state: got %0d want %0d", st[0], FREE);
    total++;
    if (load[0] === 32'h0) passed++;
    else $display("FAIL rst_mid_load: got %h want 0", load[0]);
    repeat (2) next_cycle();
    #4;
    total++;
    if (st[0] === FREE) passed++;
    else $display("FAIL rst_hold_state: got %0d want %0d", st[0], FREE);
    wen[0] = 1'b0;
    nRST = 1'b1;
    $display("reset mid-write dut0 addr=10");
    txn(0, 1'b0, 32'h10, 32'h0, 2);
  endtask

`ifdef RAM_STATS_EN
  task automatic test_stats();
    next_cycle();
    nRST = 1'b0;
    #4;
    total++;
    if (rdc[0] === 32'h0 && wrc[0] === 32'h0) passed++;
    else $display("FAIL stats_reset: rd %h wr %h want 0 0", rdc[0], wrc[0]);
    nRST = 1'b1;
    txn(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 2);
    txn(0, 1'b1, 32'h10, 32'h1010_1010, 2);
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    txn(0, 1'b0, 32'h10, 32'h0, 2);
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    next_cycle();
    ren[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h40;
    #4;
    next_cycle();
    ren[0] = 1'b0; wen[0] = 1'b0;
    #4;
    total++;
    if (rdc[0] === 32'd3) passed++;
    else $display("FAIL stats_rdcnt: got %0d want 3", rdc[0]);
    total++;
    if (wrc[0] === 32'd2) passed++;
    else $display("FAIL stats_wrcnt: got %0d want 2", wrc[0]);
    force gen_dut[0].u_dut.rdcnt_reg = 32'hFFFF_FFFF;
    #1;
    release gen_dut[0].u_dut.rdcnt_reg;
    txn(0, 1'b0, 32'h40, 32'h0, 2);
    total++;
    if (rdc[0] === 32'hFFFF_FFFF) passed++;
    else $display("FAIL stats_saturate: got %h want ffffffff", rdc[0]);
    total++;
    if (wrc[0] === 32'd2) passed++;
    else $display("FAIL stats_wrcnt_hold: got %0d want 2", wrc[0]);
    $display("stats dut0 rdcnt=%h wrcnt=%h", rdc[0], wrc[0]);
  endtask
`endif

  initial begin
    test_reset();
    test_lat2_write_read();
    test_lat1_back_to_back();
    test_addr_change();
    test_errors();
    test_reset_mid_write();
`ifdef RAM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
